apb_timer_prog_master: RTL and testbench
========================================

# apb_timer_prog_master

APB initiator that programs and polls the APB timer unit on behalf of a local controller (e.g. the cluster event/sleep logic) that has no bus master of its own. It accepts one high-level command at a time and expands it into a fixed sequence of APB3 transfers against the timer unit register map. It returns one response per command, carrying read data and error status. It sits directly in front of the timer unit's APB slave port, or on the peripheral interconnect.

## Interface
- APB_ADDR_WIDTH, 12, width of PADDR.
- BASE_ADDR, 0, timer unit base address, added to every register offset.
- TIMEOUT, 256, maximum ACCESS-phase cycles waiting for PREADY before abort (≥1).
- HCLK  in  1  clock, single clock domain.
- HRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  2  0=PROGRAM, 1=READ_VAL, 2=STOP, 3=reserved (responds with error, no APB traffic).
- cmd_tsel  in  1  32-bit mode timer select: 0=LO, 1=HI. Ignored when cmd_cfg[31] is set.
- cmd_cfg  in  32  config word; bit31 (MODE_64) selects 64-bit sequences.
- cmd_cmp  in  64  compare value; [63:32] used only in 64-bit mode.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  64  read value; zero for non-read ops.
- rsp_err  out  1  PSLVERR seen, timeout, or reserved op.
- rsp_timeout  out  1  abort caused by timeout.
- rsp_step  out  2  index of the failing transfer (0 if none).
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  write data.
- PWRITE  out  1  write strobe.
- PSEL  out  1  select.
- PENABLE  out  1  access phase.
- PRDATA  in  32  read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

## Operation
- In the sequences below, T = LO or HI, chosen by cmd_tsel. Offsets: CFG 0x0/0x4, VAL 0x8/0xC, CMP 0x10/0x14, RESET 0x20/0x24.
- PROGRAM, 32-bit: the sequence is:
  - CMP_T ← cmp[31:0]
  - RESET_T ← 1
  - CFG_T ← cfg
- PROGRAM, 64-bit: the sequence is:
  - CMP_LO ← cmp[31:0]
  - CMP_HI ← cmp[63:32]
  - RESET_LO ← 1
  - CFG_LO ← cfg
- READ_VAL, 32-bit: read VAL_T into rsp_data[31:0]; rsp_data[63:32] = 0.
- READ_VAL, 64-bit: read VAL_LO into [31:0], then VAL_HI into [63:32].
- STOP: CFG_T ← cfg with bit0 (ENABLE) forced to 0. In 64-bit mode, T = LO.
- The command is registered at acceptance; later changes to the cmd_* inputs have no effect.
- PSLVERR sampled high with PREADY:
  - remaining transfers are skipped;
  - rsp_err=1 and rsp_step = current step index;
  - read data already captured is kept; the uncaptured half is 0.
- Timeout: PREADY low for TIMEOUT consecutive ACCESS cycles.
  - PSEL and PENABLE drop on the next cycle.
  - rsp_err=1, rsp_timeout=1, rsp_step = current step index.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE→SETUP on cmd_valid, except reserved op: IDLE→RESP.
  - SETUP→ACCESS always.
  - ACCESS→SETUP on PREADY with steps remaining and no error.
  - ACCESS→RESP on PREADY at the last step, on error, or on timeout.
  - RESP→IDLE on rsp_ready.

## Timing
- Reset values:
  - cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; rsp_timeout=0; rsp_step=0.
  - PSEL=0, PENABLE=0, PWRITE=0; PADDR=0, PWDATA=0.
- cmd_ready is high only in IDLE; it is registered and is not combinational from cmd_valid.
- SETUP drives PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA valid. ACCESS holds the same values with PENABLE=1.
- Back-to-back transfers go directly ACCESS→SETUP, with no idle cycle; PSEL stays high.
- Latency with zero wait states:
  - acceptance at cycle 0;
  - each transfer takes 2 cycles;
  - rsp_valid rises at cycle 2N+1 for N transfers (PROGRAM 32-bit: cycle 7).
- rsp_* fields are stable while rsp_valid=1. A new command can be accepted the cycle after the rsp_valid&rsp_ready handshake.
- Timeout counter resets on entry to each ACCESS. Reaching TIMEOUT counts as PREADY with error.
- Asynchronous reset mid-transfer: all outputs take their reset values immediately and the command is lost.

## Structure
- Package apb_timer_prog_pkg:
  - imports the timer register offsets from apb_timer_unit_pkg;
  - defines the cmd_op enum, the FSM state typedef, and a step_t struct (offset, write, data-select).
- Sub-module apb_timer_prog_step_dec: combinational.
  - Inputs: op, mode64, tsel, step index.
  - Outputs: step_t and a last_step flag.
  - Keeps the FSM free of sequence tables.

## Test plan
- PROGRAM, 32-bit, tsel=1, cmp=0x1234, cfg=0x1, PREADY=1. Required response:
  - writes (0x14,0x1234), (0x24,1), (0x04,0x1);
  - rsp_valid at cycle 7, rsp_err=0.
- READ_VAL, 64-bit, VAL_LO=0xAAAA_0001, VAL_HI=0x5, 3 wait states per transfer. Required response:
  - rsp_data=0x0000_0005_AAAA_0001;
  - PADDR and PWDATA stable through wait states.
- PROGRAM, 64-bit, with PSLVERR on step 1. Required response:
  - only 2 transfers issued;
  - rsp_err=1, rsp_step=1.
- TIMEOUT=4, PREADY held low. Required response:
  - PENABLE high for exactly 4 cycles;
  - rsp_err=1, rsp_timeout=1.
- STOP with cfg=0xFF, followed by a reserved op. Required response:
  - the STOP writes 0xFE to 0x00;
  - the reserved op produces no PSEL activity and rsp_err=1 two cycles after acceptance.
- HRESETn asserted during ACCESS. Required response:
  - PSEL/PENABLE are 0 in the same cycle;
  - cmd_ready=1 after release;
  - the next command executes normally.

Source files
------------

// File: rtl/apb_timer_prog_pkg.sv
// Shared types for the timer programming master: command ops, FSM states, step descriptor.
package apb_timer_prog_pkg;
  import apb_timer_unit_pkg::*;

  typedef enum logic [1:0] {
    OP_PROGRAM  = 2'd0,
    OP_READ_VAL = 2'd1,
    OP_STOP     = 2'd2,
    OP_RSVD     = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    DSEL_NONE,
    DSEL_CMP_LO,
    DSEL_CMP_HI,
    DSEL_ONE,
    DSEL_CFG,
    DSEL_CFG_STOP
  } dsel_e;

  typedef struct packed {
    logic [7:0] offset;
    logic       write;
    dsel_e      dsel;
  } step_t;

  // HI registers sit one word above their LO counterpart.
  function automatic logic [7:0] sel_off(input logic hi, input logic [7:0] lo_off);
    return hi ? lo_off + 8'h04 : lo_off;
  endfunction
endpackage

// File: rtl/apb_timer_unit_pkg.sv
// Register offsets of the APB timer unit, as seen from its APB slave port.
package apb_timer_unit_pkg;
  localparam logic [7:0] TIMER_CFG_LO   = 8'h00;
  localparam logic [7:0] TIMER_CFG_HI   = 8'h04;
  localparam logic [7:0] TIMER_VAL_LO   = 8'h08;
  localparam logic [7:0] TIMER_VAL_HI   = 8'h0C;
  localparam logic [7:0] TIMER_CMP_LO   = 8'h10;
  localparam logic [7:0] TIMER_CMP_HI   = 8'h14;
  localparam logic [7:0] TIMER_RESET_LO = 8'h20;
  localparam logic [7:0] TIMER_RESET_HI = 8'h24;
endpackage

// File: rtl/apb_timer_prog_master_if.sv
// APB3 bus between the programming master and the timer unit slave.
interface apb_timer_prog_master_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [31:0]           PWDATA;
  logic [31:0]           PRDATA;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_prog_step_dec.sv
// Maps (op, mode, timer select, step index) to the APB transfer for that step.
module apb_timer_prog_step_dec
  import apb_timer_prog_pkg::*;
  import apb_timer_unit_pkg::*;
(
  input  cmd_op_e    op,
  input  logic       mode64,
  input  logic       tsel,
  input  logic [1:0] step_idx,
  output step_t      step,
  output logic       last_step
);
  logic hi;

  // 64-bit sequences always target the LO half unless they name HI explicitly.
  assign hi = tsel & ~mode64;

  always_comb begin
    step      = '{offset: 8'h00, write: 1'b0, dsel: DSEL_NONE};
    last_step = 1'b1;
    case (op)
      OP_PROGRAM: begin
        if (mode64) begin
          last_step = (step_idx == 2'd3);
          case (step_idx)
            2'd0:    step = '{TIMER_CMP_LO,   1'b1, DSEL_CMP_LO};
            2'd1:    step = '{TIMER_CMP_HI,   1'b1, DSEL_CMP_HI};
            2'd2:    step = '{TIMER_RESET_LO, 1'b1, DSEL_ONE};
            default: step = '{TIMER_CFG_LO,   1'b1, DSEL_CFG};
          endcase
        end else begin
          last_step = (step_idx == 2'd2);
          case (step_idx)
            2'd0:    step = '{sel_off(hi, TIMER_CMP_LO),   1'b1, DSEL_CMP_LO};
            2'd1:    step = '{sel_off(hi, TIMER_RESET_LO), 1'b1, DSEL_ONE};
            default: step = '{sel_off(hi, TIMER_CFG_LO),   1'b1, DSEL_CFG};
          endcase
        end
      end
      OP_READ_VAL: begin
        last_step = !mode64 || (step_idx == 2'd1);
        step = '{sel_off(mode64 ? step_idx[0] : hi, TIMER_VAL_LO), 1'b0, DSEL_NONE};
      end
      OP_STOP: step = '{sel_off(hi, TIMER_CFG_LO), 1'b1, DSEL_CFG_STOP};
      default: ;
    endcase
  end
endmodule

// File: rtl/apb_timer_prog_master.sv
// APB3 initiator expanding one high-level timer command into a sequence of
// register transfers and returning a single response per command.
module apb_timer_prog_master
  import apb_timer_prog_pkg::*;
#(
  parameter int                        APB_ADDR_WIDTH = 12,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        TIMEOUT        = 256
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  // cmd_* and rsp_* are valid/ready channels: a beat moves on a rising edge
  // where valid and ready are both high; the sender holds its payload until then.
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic                           cmd_tsel,
  input  logic [31:0]                    cmd_cfg,
  input  logic [63:0]                    cmd_cmp,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [63:0]                    rsp_data,
  output logic                           rsp_err,
  output logic                           rsp_timeout,
  output logic [1:0]                     rsp_step,
  apb_timer_prog_master_if.master        apb,
  output state_e                         dbg_state
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state, state_nxt;
  cmd_op_e         op_q;
  logic            mode64_q, tsel_q;
  logic [31:0]     cfg_q;
  logic [63:0]     cmp_q;
  logic [1:0]      step_q, err_step_q;
  logic [CW-1:0]   wait_q;
  logic [63:0]     data_q;
  logic            err_q, to_q;
  step_t           step;
  logic            last_step;
  logic            busy, accept, xfer_done, xfer_to, xfer_err;
  logic [31:0]     wdata;

  apb_timer_prog_step_dec u_step_dec (
    .op        (op_q),
    .mode64    (mode64_q),
    .tsel      (tsel_q),
    .step_idx  (step_q),
    .step      (step),
    .last_step (last_step)
  );

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign busy      = (state == ST_SETUP) || (state == ST_ACCESS);
  assign xfer_done = (state == ST_ACCESS) && apb.PREADY;
  // The TIMEOUT-th consecutive not-ready ACCESS cycle is treated as an errored completion.
  assign xfer_to   = (state == ST_ACCESS) && !apb.PREADY && (wait_q == CW'(TIMEOUT - 1));
  assign xfer_err  = xfer_to || (xfer_done && apb.PSLVERR);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cmd_valid) state_nxt = (cmd_op == OP_RSVD) ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (xfer_err || (xfer_done && last_step)) state_nxt = ST_RESP;
        else if (xfer_done)                       state_nxt = ST_SETUP;
      end
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      op_q       <= OP_PROGRAM;
      mode64_q   <= 1'b0;
      tsel_q     <= 1'b0;
      cfg_q      <= '0;
      cmp_q      <= '0;
      step_q     <= '0;
      wait_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
      err_step_q <= '0;
    end else begin
      if (accept) begin
        op_q       <= cmd_op_e'(cmd_op);
        mode64_q   <= cmd_cfg[31];
        tsel_q     <= cmd_tsel;
        cfg_q      <= cmd_cfg;
        cmp_q      <= cmd_cmp;
        step_q     <= '0;
        data_q     <= '0;
        err_q      <= (cmd_op == OP_RSVD);
        to_q       <= 1'b0;
        err_step_q <= '0;
      end
      if (state == ST_SETUP)                       wait_q <= '0;
      else if (state == ST_ACCESS && !apb.PREADY)  wait_q <= wait_q + 1'b1;
      if (xfer_done && !apb.PSLVERR) begin
        if (!step.write) begin
          if (step_q[0]) data_q[63:32] <= apb.PRDATA;
          else           data_q[31:0]  <= apb.PRDATA;
        end
        if (!last_step) step_q <= step_q + 2'd1;
      end
      if (xfer_err) begin
        err_q      <= 1'b1;
        to_q       <= xfer_to;
        err_step_q <= step_q;
      end
    end
  end

  always_comb begin
    wdata = '0;
    case (step.dsel)
      DSEL_CMP_LO:   wdata = cmp_q[31:0];
      DSEL_CMP_HI:   wdata = cmp_q[63:32];
      DSEL_ONE:      wdata = 32'd1;
      DSEL_CFG:      wdata = cfg_q;
      DSEL_CFG_STOP: wdata = {cfg_q[31:1], 1'b0};
      default:       wdata = '0;
    endcase
  end

  // Bus outputs decode the state register so an async reset clears them at once.
  assign apb.PSEL    = busy;
  assign apb.PENABLE = (state == ST_ACCESS);
  assign apb.PWRITE  = busy && step.write;
  assign apb.PADDR   = busy ? BASE_ADDR + APB_ADDR_WIDTH'(step.offset) : '0;
  assign apb.PWDATA  = (busy && step.write) ? wdata : '0;

  assign cmd_ready   = (state == ST_IDLE);
  assign rsp_valid   = (state == ST_RESP);
  assign rsp_data    = data_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign rsp_step    = err_step_q;
  assign dbg_state   = state;
endmodule

// File: tb/tb_apb_timer_prog_master.sv
// Directed plus randomized bench for apb_timer_prog_master against a
// transfer-list reference model and a behavioural APB slave.
module tb_apb_timer_prog_master;
  import apb_timer_prog_pkg::*;

  localparam int TMO = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic        cmd_tsel = 1'b0;
  logic [31:0] cmd_cfg = '0;
  logic [63:0] cmd_cmp = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [1:0]  rsp_step;
  state_e      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  apb_timer_prog_master_if #(.ADDR_WIDTH(12)) apb ();

  apb_timer_prog_master #(
    .APB_ADDR_WIDTH (12),
    .BASE_ADDR      (12'h000),
    .TIMEOUT        (TMO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_tsel    (cmd_tsel),
    .cmd_cfg     (cmd_cfg),
    .cmd_cmp     (cmd_cmp),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .rsp_step    (rsp_step),
    .apb         (apb),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 HCLK = ~HCLK;

  // ---------------- behavioural APB slave ----------------
  logic [31:0] mem [16];
  int          wait_states = 0;
  bit          hold_low = 1'b0;
  int          err_abs = -1;
  int          xfer_total = 0;
  int          wcnt = 0;
  logic [11:0] log_a [$];
  logic        log_w [$];
  logic [31:0] log_d [$];

  assign apb.PREADY  = apb.PSEL && apb.PENABLE && !hold_low && (wcnt >= wait_states);
  assign apb.PSLVERR = apb.PREADY && (xfer_total == err_abs);
  assign apb.PRDATA  = mem[apb.PADDR[5:2]];

  always @(posedge HCLK) begin
    if (apb.PSEL && apb.PENABLE && !apb.PREADY) wcnt <= wcnt + 1;
    else                                        wcnt <= 0;
    if (apb.PREADY) begin
      xfer_total <= xfer_total + 1;
      log_a.push_back(apb.PADDR);
      log_w.push_back(apb.PWRITE);
      log_d.push_back(apb.PWDATA);
    end
  end

  // ---------------- bus monitor ----------------
  int          psel_cnt = 0;
  int          pen_cnt = 0;
  int          stab_cnt = 0;
  logic [11:0] cap_a = '0;
  logic [31:0] cap_d = '0;
  logic        cap_w = 1'b0;

  always @(posedge HCLK) begin
    if (apb.PSEL)    psel_cnt <= psel_cnt + 1;
    if (apb.PENABLE) pen_cnt  <= pen_cnt + 1;
    if (apb.PSEL && !apb.PENABLE) begin
      cap_a <= apb.PADDR;
      cap_d <= apb.PWDATA;
      cap_w <= apb.PWRITE;
    end else if (apb.PENABLE && (!apb.PSEL || apb.PADDR !== cap_a ||
                                 apb.PWDATA !== cap_d || apb.PWRITE !== cap_w)) begin
      stab_cnt <= stab_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [11:0] exp_addr_q [$];
  logic        exp_wr_q [$];
  logic [31:0] exp_wd_q [$];
  logic [63:0] exp_data;
  logic        exp_err, exp_to;
  logic [1:0]  exp_step;
  int          exp_lat, exp_nlog, exp_psel, exp_pen;

  task automatic add(input logic [11:0] a, input logic w, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_wr_q.push_back(w);
    exp_wd_q.push_back(d);
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic tsel, input logic [31:0] cfg,
                           input logic [63:0] cmp, input int err_at, input bit to, input int waits);
    logic [11:0] t;
    int n, issued;
    t = (cfg[31] || !tsel) ? 12'h000 : 12'h004;
    exp_addr_q.delete(); exp_wr_q.delete(); exp_wd_q.delete();
    case (op)
      2'd0: begin
        if (cfg[31]) begin
          add(12'h010, 1'b1, cmp[31:0]); add(12'h014, 1'b1, cmp[63:32]);
          add(12'h020, 1'b1, 32'd1);     add(12'h000, 1'b1, cfg);
        end else begin
          add(12'h010 + t, 1'b1, cmp[31:0]); add(12'h020 + t, 1'b1, 32'd1);
          add(12'h000 + t, 1'b1, cfg);
        end
      end
      2'd1: begin
        if (cfg[31]) begin add(12'h008, 1'b0, 32'd0); add(12'h00C, 1'b0, 32'd0); end
        else add(12'h008 + t, 1'b0, 32'd0);
      end
      2'd2: add(12'h000 + t, 1'b1, cfg & 32'hFFFF_FFFE);
      default: ;
    endcase
    n = exp_addr_q.size();
    issued = n; exp_err = (op == 2'd3); exp_to = 1'b0; exp_step = 2'd0; exp_data = '0;
    if (op != 2'd3 && to) begin
      issued = 1; exp_err = 1'b1; exp_to = 1'b1;
    end else if (err_at >= 0 && err_at < n) begin
      issued = err_at + 1; exp_err = 1'b1; exp_step = 2'(err_at);
    end
    for (int i = 0; i < issued; i++)
      if (!exp_wr_q[i] && !(exp_err && i == issued - 1))
        exp_data[32*i +: 32] = mem[exp_addr_q[i][5:2]];
    exp_nlog = (op != 2'd3 && to) ? 0 : issued;
    if (op == 2'd3) begin
      exp_lat = 1; exp_psel = 0; exp_pen = 0;
    end else if (to) begin
      exp_lat = TMO + 2; exp_psel = TMO + 1; exp_pen = TMO;
    end else begin
      exp_lat = issued * (2 + waits) + 1; exp_psel = issued * (2 + waits); exp_pen = issued * (1 + waits);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic tsel, input logic [31:0] cfg,
                         input logic [63:0] cmp, input int err_at, input bit to, input int waits);
    int  l0, p0, e0, s0, lat;
    bit  seen;
    model_cmd(op, tsel, cfg, cmp, err_at, to, waits);
    @(negedge HCLK);
    wait_states = waits;
    hold_low    = to;
    err_abs     = (err_at >= 0) ? xfer_total + err_at : -1;
    l0 = log_a.size(); p0 = psel_cnt; e0 = pen_cnt; s0 = stab_cnt;
    check({tag, "/cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_tsel = tsel; cmd_cfg = cfg; cmd_cmp = cmp;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_tsel  = 1'($urandom_range(0, 1));
    cmd_cfg   = $urandom;
    cmd_cmp   = {$urandom, $urandom};
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge HCLK);
      lat++;
      seen = rsp_valid;
    end
    check({tag, "/rsp_valid_seen"}, seen, 1);
    if (op == 2'd3) check({tag, "/latency_le2"}, (lat <= 2), 1);
    else            check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/rsp_data"},    rsp_data,    exp_data);
    check({tag, "/rsp_err"},     rsp_err,     exp_err);
    check({tag, "/rsp_timeout"}, rsp_timeout, exp_to);
    check({tag, "/rsp_step"},    rsp_step,    exp_step);
    check({tag, "/n_xfers"},     log_a.size() - l0, exp_nlog);
    for (int i = 0; i < exp_nlog; i++) begin
      if (l0 + i < log_a.size()) begin
        check({tag, "/paddr"},  log_a[l0 + i], exp_addr_q[i]);
        check({tag, "/pwrite"}, log_w[l0 + i], exp_wr_q[i]);
        if (exp_wr_q[i]) check({tag, "/pwdata"}, log_d[l0 + i], exp_wd_q[i]);
      end
    end
    check({tag, "/psel_cycles"},    psel_cnt - p0, exp_psel);
    check({tag, "/penable_cycles"}, pen_cnt - e0,  exp_pen);
    check({tag, "/bus_stable"},     stab_cnt - s0, 0);
    repeat ($urandom_range(0, 2)) @(negedge HCLK);
    check({tag, "/rsp_hold_valid"}, rsp_valid, 1);
    check({tag, "/rsp_hold_data"},  rsp_data,  exp_data);
    check({tag, "/rsp_hold_err"},   rsp_err,   exp_err);
    rsp_ready = 1'b1;
    @(posedge HCLK); #1;
    rsp_ready = 1'b0;
    @(negedge HCLK);
    check({tag, "/idle_cmd_ready"}, cmd_ready, 1);
    check({tag, "/idle_rsp_valid"}, rsp_valid, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit seen;
    int k;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    repeat (3) @(negedge HCLK);
    check("rst/state",       dbg_state,   ST_IDLE);
    check("rst/cmd_ready",   cmd_ready,   1);
    check("rst/rsp_valid",   rsp_valid,   0);
    check("rst/rsp_data",    rsp_data,    0);
    check("rst/rsp_err",     rsp_err,     0);
    check("rst/rsp_timeout", rsp_timeout, 0);
    check("rst/rsp_step",    rsp_step,    0);
    check("rst/psel",        apb.PSEL,    0);
    check("rst/penable",     apb.PENABLE, 0);
    check("rst/pwrite",      apb.PWRITE,  0);
    check("rst/paddr",       apb.PADDR,   0);
    check("rst/pwdata",      apb.PWDATA,  0);
    HRESETn = 1'b1;

    run_cmd("prog32",  2'd0, 1'b1, 32'h0000_0001, 64'h1234, -1, 1'b0, 0);
    mem[2] = 32'hAAAA_0001;
    mem[3] = 32'h0000_0005;
    run_cmd("read64",  2'd1, 1'b0, 32'h8000_0000, 64'h0, -1, 1'b0, 3);
    run_cmd("prog64e", 2'd0, 1'b0, 32'h8000_0001, 64'hDEAD_BEEF_0000_1111, 1, 1'b0, 0);
    run_cmd("tmo",     2'd0, 1'b0, 32'h0000_0001, 64'h77, -1, 1'b1, 0);
    run_cmd("stop",    2'd2, 1'b0, 32'h0000_00FF, 64'h0, -1, 1'b0, 0);
    run_cmd("rsvd",    2'd3, 1'b0, 32'h0000_00FF, 64'h0, -1, 1'b0, 0);
    run_cmd("read32e", 2'd1, 1'b1, 32'h0000_0000, 64'h0, 0, 1'b0, 1);

    // Async reset while a transfer sits in ACCESS.
    @(negedge HCLK);
    wait_states = 3; hold_low = 1'b0; err_abs = -1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_tsel = 1'b0; cmd_cfg = 32'h1; cmd_cmp = 64'h55;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(negedge HCLK);
      k++;
      seen = apb.PENABLE;
    end
    check("arst/reach_access", seen, 1);
    HRESETn = 1'b0;
    #1;
    check("arst/psel",      apb.PSEL,    0);
    check("arst/penable",   apb.PENABLE, 0);
    check("arst/rsp_valid", rsp_valid,   0);
    check("arst/state",     dbg_state,   ST_IDLE);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("arst/cmd_ready", cmd_ready, 1);
    run_cmd("post_rst", 2'd0, 1'b1, 32'h0000_0003, 64'hABCD, -1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_cfg;
      int          r_err;
      mem[2] = $urandom; mem[3] = $urandom; mem[4] = $urandom;
      r_op  = 2'($urandom_range(0, 3));
      r_cfg = $urandom;
      r_err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_cmd("rand", r_op, 1'($urandom_range(0, 1)), r_cfg, {$urandom, $urandom},
              r_err, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
